decode_regfile: RTL and testbench
=================================

DECODE_REGFILE -- requirements
Module: decode_regfile

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, fetched instruction fields present this cycle.
REQ-004 SHALL have ports icode and ifun, input, 4 each, instruction code and function from fetch.
REQ-005 SHALL have ports rA and rB, input, 4 each, register specifiers from fetch; 4'hF means none.
REQ-006 SHALL have ports wb_en, input, 1, writeback strobe; wb_dstE/wb_dstM, input, 4 each, write destinations; wb_valE/wb_valM, input, 64 each, write data.
REQ-007 SHALL have ports srcA, srcB, dstE, dstM, output, 4 each, decoded register IDs, registered.
REQ-008 SHALL have ports valA and valB, output, 64 each, register read data, registered.
REQ-009 SHALL have port out_valid, output, 1, outputs hold a decoded instruction.
REQ-010 SHALL have port out_err, output, 1, decoded icode is greater than 4'hB.

Function
REQ-011 SHALL contain 15 architectural 64-bit registers, IDs 0..14; ID 4'hF SHALL never be read or written.
REQ-012 SHALL set srcA from the icode: rA for icodes 2, 4, 6, A; 4'h4 (rsp) for icodes 9, B; 4'hF otherwise.
REQ-013 SHALL set srcB from the icode: rB for icodes 4, 5, 6; 4'h4 for icodes 8, 9, A, B; 4'hF otherwise.
REQ-014 SHALL set dstE from the icode: rB for icodes 2, 3, 6; 4'h4 for icodes 8, 9, A, B; 4'hF otherwise. Conditional cancel of cmovXX is not this block's job; writeback supplies the final wb_dstE.
REQ-015 SHALL set dstM to rA for icodes 5 and B, and to 4'hF otherwise.
REQ-016 SHALL read 0 for valA/valB whenever the corresponding src is 4'hF.
REQ-017 SHALL give latency 1: in_valid sampled high at edge N produces out_valid=1 with valid src/dst/valA/valB from edge N until edge N+1.
REQ-018 SHALL capture nothing when in_valid is low at an edge; out_valid SHALL then be 0 and the other outputs SHALL hold their previous values.
REQ-019 SHALL, for icode greater than 4'hB, set out_err=1, set all src/dst to 4'hF, set valA=valB=0, and still assert out_valid.
REQ-020 SHALL, at an edge with wb_en=1, write wb_valE to R[wb_dstE] if wb_dstE is not F, and write wb_valM to R[wb_dstM] if wb_dstM is not F.
REQ-021 SHALL let wb_valM win when wb_dstE equals wb_dstM and neither is F (popq %rsp case).
REQ-022 SHALL bypass writeback to reads: when a same-edge writeback targets srcA or srcB, the captured valA/valB SHALL be the new value, with valM taking priority over valE.
REQ-023 SHALL ignore wb_dst* and wb_val* when wb_en=0.

Reset
REQ-024 SHALL, at an edge with rst=1, clear all 15 registers to 0, out_valid=0, out_err=0, srcA/srcB/dstE/dstM=4'hF, and valA/valB=0.
REQ-025 SHALL give rst priority over wb_en and in_valid in the same cycle; a pending instruction or writeback is discarded.
REQ-026 SHALL make the first capture at the first edge with rst=0 and in_valid=1.

Structure
REQ-027 SHALL place icode constants (IHALT..IPOPQ = 0..B), RNONE=4'hF and RRSP=4'h4 in shared package y86_pkg, also used by fetch and execute.
REQ-028 SHALL implement the storage as sub-module regfile_15x64, with 2 combinational read ports, 2 write ports, M-over-E priority and the bypass; decode logic and the output register stay in decode_regfile.

Verification
REQ-029 Reset, then irmovq (icode 3, rA=F, rB=2) -> next edge: dstE=2, srcA=srcB=dstM=F, valA=valB=0, out_valid=1.
REQ-030 Write R[3]=0x1122334455667788 via wb, then OPq (icode 6, rA=3, rB=3) -> valA=valB=0x1122334455667788.
REQ-031 popq (icode B, rA=4) with same-edge wb_dstE=4/valE=0x100, wb_dstM=4/valM=0x200 -> R[4]=0x200; a later read of rsp returns 0x200.
REQ-032 pushq (icode A, rA=1) while the same edge writes R[1]=0xDEAD -> valA=0xDEAD (bypass), srcB=4, dstE=4.
REQ-033 icode=C -> out_err=1, all src/dst=F, out_valid=1; rst asserted mid-stream with wb_en=1 -> all registers read 0 afterwards.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings (instruction codes, register IDs) plus the
// decode table that maps an instruction to its source/destination registers.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam int NUM_REGS = 15;
  localparam int WORD_W   = 64;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       err;
  } dec_ids_t;

  // Illegal icodes decode to "no registers" so nothing downstream reads or writes.
  function automatic dec_ids_t decode_ids(input logic [3:0] icode,
                                          input logic [3:0] ra,
                                          input logic [3:0] rb);
    dec_ids_t d;
    d.src_a = RNONE;
    d.src_b = RNONE;
    d.dst_e = RNONE;
    d.dst_m = RNONE;
    d.err   = (icode > IPOPQ);

    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: d.src_a = ra;
      IRET, IPOPQ:                    d.src_a = RRSP;
      default:                        d.src_a = RNONE;
    endcase

    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         d.src_b = rb;
      ICALL, IRET, IPUSHQ, IPOPQ:     d.src_b = RRSP;
      default:                        d.src_b = RNONE;
    endcase

    case (icode)
      IRRMOVQ, IIRMOVQ, IOPQ:         d.dst_e = rb;
      ICALL, IRET, IPUSHQ, IPOPQ:     d.dst_e = RRSP;
      default:                        d.dst_e = RNONE;
    endcase

    case (icode)
      IMRMOVQ, IPOPQ:                 d.dst_m = ra;
      default:                        d.dst_m = RNONE;
    endcase

    return d;
  endfunction

endpackage

// File: rtl/regfile_15x64.sv
// Fifteen 64-bit architectural registers: two combinational read ports with
// same-edge writeback bypass, two write ports where port M beats port E.
module regfile_15x64
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rd_a_id,
  input  logic [3:0]        rd_b_id,
  output logic [WORD_W-1:0] rd_a_data,
  output logic [WORD_W-1:0] rd_b_data,
  input  logic              wr_en,
  input  logic [3:0]        wr_e_id,
  input  logic [WORD_W-1:0] wr_e_data,
  input  logic [3:0]        wr_m_id,
  input  logic [WORD_W-1:0] wr_m_data
);

  logic [WORD_W-1:0] regs_q [NUM_REGS];
  logic [WORD_W-1:0] regs_d [NUM_REGS];

  // ID 4'hF never matches a loop index, so it is never written.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_e_id == 4'(i))) regs_d[i] = wr_e_data;
      if (wr_en && (wr_m_id == 4'(i))) regs_d[i] = wr_m_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Reads of 4'hF return zero; a same-edge write is forwarded, M before E.
  always_comb begin
    rd_a_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_a_id == 4'(i)) rd_a_data = regs_q[i];
    end
    if (wr_en && (rd_a_id != RNONE)) begin
      if (wr_m_id == rd_a_id)      rd_a_data = wr_m_data;
      else if (wr_e_id == rd_a_id) rd_a_data = wr_e_data;
    end
  end

  always_comb begin
    rd_b_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_b_id == 4'(i)) rd_b_data = regs_q[i];
    end
    if (wr_en && (rd_b_id != RNONE)) begin
      if (wr_m_id == rd_b_id)      rd_b_data = wr_m_data;
      else if (wr_e_id == rd_b_id) rd_b_data = wr_e_data;
    end
  end

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: picks register IDs from icode/rA/rB, reads the
// register file and registers the result for execute one cycle later.
module decode_regfile
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              wb_en,
  input  logic [3:0]        wb_dstE,
  input  logic [3:0]        wb_dstM,
  input  logic [WORD_W-1:0] wb_valE,
  input  logic [WORD_W-1:0] wb_valM,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [WORD_W-1:0] valA,
  output logic [WORD_W-1:0] valB,
  output logic              out_valid,
  output logic              out_err
);

  dec_ids_t          ids;
  logic [WORD_W-1:0] rd_a_data;
  logic [WORD_W-1:0] rd_b_data;

  logic [3:0]        src_a_q, src_a_d;
  logic [3:0]        src_b_q, src_b_d;
  logic [3:0]        dst_e_q, dst_e_d;
  logic [3:0]        dst_m_q, dst_m_d;
  logic [WORD_W-1:0] val_a_q, val_a_d;
  logic [WORD_W-1:0] val_b_q, val_b_d;
  logic              out_valid_q, out_valid_d;
  logic              out_err_q, out_err_d;

  // ifun only matters to execute; it passes through this stage untouched.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  always_comb begin
    ids = decode_ids(icode, rA, rB);
  end

  regfile_15x64 u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_a_id   (ids.src_a),
    .rd_b_id   (ids.src_b),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .wr_en     (wb_en),
    .wr_e_id   (wb_dstE),
    .wr_e_data (wb_valE),
    .wr_m_id   (wb_dstM),
    .wr_m_data (wb_valM)
  );

  // Without in_valid the IDs and data hold; only out_valid drops.
  always_comb begin
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dst_e_d     = dst_e_q;
    dst_m_d     = dst_m_q;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    out_err_d   = out_err_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      src_a_d     = ids.src_a;
      src_b_d     = ids.src_b;
      dst_e_d     = ids.dst_e;
      dst_m_d     = ids.dst_m;
      val_a_d     = rd_a_data;
      val_b_d     = rd_b_data;
      out_err_d   = ids.err;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_a_q     <= RNONE;
      src_b_q     <= RNONE;
      dst_e_q     <= RNONE;
      dst_m_q     <= RNONE;
      val_a_q     <= '0;
      val_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dst_e_q     <= dst_e_d;
      dst_m_q     <= dst_m_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign srcA      = src_a_q;
  assign srcB      = src_b_q;
  assign dstE      = dst_e_q;
  assign dstM      = dst_m_q;
  assign valA      = val_a_q;
  assign valB      = val_b_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: each step drives one edge, then checks
// the registered outputs against hand-computed values.
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  icode, ifun, rA, rB;
  logic        wb_en;
  logic [3:0]  wb_dstE, wb_dstM;
  logic [63:0] wb_valE, wb_valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB;
  logic        out_valid, out_err;

  int numCompared   = 0;
  int numMismatched = 0;

  always #5 clk = ~clk;

  decode_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .icode     (icode),
    .ifun      (ifun),
    .rA        (rA),
    .rB        (rB),
    .wb_en     (wb_en),
    .wb_dstE   (wb_dstE),
    .wb_dstM   (wb_dstM),
    .wb_valE   (wb_valE),
    .wb_valM   (wb_valM),
    .srcA      (srcA),
    .srcB      (srcB),
    .dstE      (dstE),
    .dstM      (dstM),
    .valA      (valA),
    .valB      (valB),
    .out_valid (out_valid),
    .out_err   (out_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setWriteback(input logic en, input logic [3:0] de, input logic [3:0] dm,
                              input logic [63:0] ve, input logic [63:0] vm);
    wb_en   = en;
    wb_dstE = de;
    wb_dstM = dm;
    wb_valE = ve;
    wb_valM = vm;
  endtask

  // Drives one edge, samples 1 time unit later, then clears the writeback strobe.
  task automatic applyStimulus(input logic r, input logic iv, input logic [3:0] ic,
                               input logic [3:0] ra, input logic [3:0] rb);
    rst      = r;
    in_valid = iv;
    icode    = ic;
    ifun     = 4'h0;
    rA       = ra;
    rB       = rb;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
  endtask

  task automatic checkDecode(input string tag, input logic [3:0] sa, input logic [3:0] sb,
                             input logic [3:0] de, input logic [3:0] dm,
                             input logic [63:0] va, input logic [63:0] vb,
                             input logic ov, input logic oe);
    checkOutput({tag, ".srcA"}, 64'(srcA), 64'(sa));
    checkOutput({tag, ".srcB"}, 64'(srcB), 64'(sb));
    checkOutput({tag, ".dstE"}, 64'(dstE), 64'(de));
    checkOutput({tag, ".dstM"}, 64'(dstM), 64'(dm));
    checkOutput({tag, ".valA"}, valA, va);
    checkOutput({tag, ".valB"}, valB, vb);
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    checkOutput({tag, ".out_err"}, 64'(out_err), 64'(oe));
  endtask

  initial begin
    setWriteback(1'b1, 4'h3, 4'h5, 64'hAAAA, 64'hBBBB);
    applyStimulus(1'b1, 1'b1, 4'h6, 4'h3, 4'h5);
    setWriteback(1'b1, 4'h3, 4'h5, 64'hAAAA, 64'hBBBB);
    applyStimulus(1'b1, 1'b1, 4'h6, 4'h3, 4'h5);
    checkDecode("reset", 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);

    // irmovq $v, %rdx
    applyStimulus(1'b0, 1'b1, 4'h3, 4'hF, 4'h2);
    checkDecode("irmovq", 4'hF, 4'hF, 4'h2, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0);

    // Idle cycle writing R[3]; outputs hold, out_valid drops
    setWriteback(1'b1, 4'h3, 4'hF, 64'h1122334455667788, 64'hFFFF);
    applyStimulus(1'b0, 1'b0, 4'h6, 4'h3, 4'h3);
    checkDecode("idle_hold", 4'hF, 4'hF, 4'h2, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'h6, 4'h3, 4'h3);
    checkDecode("opq_r3", 4'h3, 4'h3, 4'h3, 4'hF, 64'h1122334455667788,
                64'h1122334455667788, 1'b1, 1'b0);

    // popq %rsp with both writeback ports on rsp: M wins, bypassed
    setWriteback(1'b1, 4'h4, 4'h4, 64'h100, 64'h200);
    applyStimulus(1'b0, 1'b1, 4'hB, 4'h4, 4'hF);
    checkDecode("popq_rsp", 4'h4, 4'h4, 4'h4, 4'h4, 64'h200, 64'h200, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'h2, 4'h4, 4'h5);
    checkDecode("rrmovq_rsp", 4'h4, 4'hF, 4'h5, 4'hF, 64'h200, 64'h0, 1'b1, 1'b0);

    // pushq %rcx while R[1] is written this edge
    setWriteback(1'b1, 4'h1, 4'hF, 64'hDEAD, 64'h0);
    applyStimulus(1'b0, 1'b1, 4'hA, 4'h1, 4'hF);
    checkDecode("pushq_bypass", 4'h1, 4'h4, 4'h4, 4'hF, 64'hDEAD, 64'h200, 1'b1, 1'b0);

    // Writeback fields with wb_en low must be ignored
    setWriteback(1'b0, 4'h1, 4'h4, 64'hBAD0, 64'hBAD1);
    applyStimulus(1'b0, 1'b1, 4'h5, 4'h1, 4'h1);
    checkDecode("mrmovq_noen", 4'hF, 4'h1, 4'hF, 4'h1, 64'h0, 64'hDEAD, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'hC, 4'h1, 4'h1);
    checkDecode("illegal_c", 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1, 1'b1);

    applyStimulus(1'b0, 1'b1, 4'hF, 4'h2, 4'h3);
    checkDecode("illegal_f", 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1, 1'b1);

    applyStimulus(1'b0, 1'b1, 4'h4, 4'h1, 4'h4);
    checkDecode("rmmovq", 4'h1, 4'h4, 4'hF, 4'hF, 64'hDEAD, 64'h200, 1'b1, 1'b0);

    // Reset mid-stream with a pending writeback and instruction
    setWriteback(1'b1, 4'h2, 4'h3, 64'h55, 64'h66);
    applyStimulus(1'b1, 1'b1, 4'h6, 4'h1, 4'h4);
    checkDecode("mid_reset", 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'h6, 4'h1, 4'h4);
    checkDecode("post_rst_a", 4'h1, 4'h4, 4'h4, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'h6, 4'h3, 4'h2);
    checkDecode("post_rst_b", 4'h3, 4'h2, 4'h2, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0);

    // Two different destinations written on one edge
    setWriteback(1'b1, 4'h6, 4'h7, 64'h66, 64'h77);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'hF, 4'hF);
    checkDecode("dual_wr_hold", 4'h3, 4'h2, 4'h2, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'h6, 4'h6, 4'h7);
    checkDecode("dual_wr_read", 4'h6, 4'h7, 4'h7, 4'hF, 64'h66, 64'h77, 1'b1, 1'b0);

    // Register 14 and the call/ret rsp encodings
    setWriteback(1'b1, 4'hE, 4'hF, 64'hE0E0, 64'h0);
    applyStimulus(1'b0, 1'b1, 4'h8, 4'hF, 4'hF);
    checkDecode("call", 4'hF, 4'h4, 4'h4, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'h9, 4'hE, 4'hE);
    checkDecode("ret", 4'h4, 4'h4, 4'h4, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 4'h4, 4'hE, 4'h7);
    checkDecode("read_r14", 4'hE, 4'h7, 4'hF, 4'hF, 64'hE0E0, 64'h77, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
